// File: rtl/memory_game_pkg.sv
// Shared types and constants for the 4x4 memory game controller.
package memory_game_pkg;

    typedef enum logic [2:0] {
        FIRST   = 3'd0,
        SECOND  = 3'd1,
        COMPARE = 3'd2,
        SHOW    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int NUM_CARDS = 16;
    localparam int NUM_PAIRS = 8;
    localparam int FACE_W    = 3;
    localparam int POS_W     = 4;

    // Position i holds face ID i>>1, i.e. pairs sit on neighbouring positions.
    localparam logic [NUM_CARDS*FACE_W-1:0] DEFAULT_LAYOUT = 48'hFF6B646D2240;

endpackage

// File: rtl/card_face_lookup.sv
// Combinational face-ID lookup: selects the 3-bit field of LAYOUT owned by a position.
module card_face_lookup
    import memory_game_pkg::*;
#(
    parameter logic [NUM_CARDS*FACE_W-1:0] LAYOUT = DEFAULT_LAYOUT
) (
    input  logic [POS_W-1:0]  i_pos,
    output logic [FACE_W-1:0] o_face
);

    assign o_face = LAYOUT[i_pos*FACE_W +: FACE_W];

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory game sequencer: picks, compare, timed reveal of mismatches, pair/attempt tracking.
// Optional attempt limit enabled by defining MOVE_LIMIT_EN.
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int unsigned                 SHOW_CYCLES  = 50_000_000,
    parameter logic [NUM_CARDS*FACE_W-1:0] LAYOUT       = DEFAULT_LAYOUT,
    parameter logic [7:0]                  MAX_ATTEMPTS = 8'd30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [POS_W-1:0]     pos,
    input  logic                 select,
    input  logic                 new_game,
    output logic [NUM_CARDS-1:0] face_up,
    output logic [NUM_CARDS-1:0] matched,
    output logic [3:0]           pairs_found,
    output logic [7:0]           attempts,
    output logic                 busy,
    output logic                 game_over,
    output logic                 game_lost
);

    localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SHOW_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [NUM_CARDS-1:0] r_face_up, r_matched;
    logic [3:0]           r_pairs;
    logic [7:0]           r_attempts;
    logic [TMR_W-1:0]     r_timer;
    logic [POS_W-1:0]     r_pick_a, r_pick_b;
    logic                 r_lost;

    logic [FACE_W-1:0]    w_face_a, w_face_b;
    logic [NUM_CARDS-1:0] w_pos_oh, w_pick_mask;
    logic                 w_sel_ok, w_equal, w_last_pair, w_loss, w_tmr_zero;

    card_face_lookup #(.LAYOUT(LAYOUT)) u_lookup_a (.i_pos(r_pick_a), .o_face(w_face_a));
    card_face_lookup #(.LAYOUT(LAYOUT)) u_lookup_b (.i_pos(r_pick_b), .o_face(w_face_b));

    assign w_pos_oh    = NUM_CARDS'(1) << pos;
    assign w_pick_mask = (NUM_CARDS'(1) << r_pick_a) | (NUM_CARDS'(1) << r_pick_b);
    assign w_sel_ok    = select && (r_state == FIRST || r_state == SECOND)
                         && !r_matched[pos] && !r_face_up[pos];
    assign w_equal     = (w_face_a == w_face_b);
    assign w_last_pair = (r_pairs == 4'(NUM_PAIRS - 1));
    assign w_tmr_zero  = (r_timer == '0);

`ifdef MOVE_LIMIT_EN
    // attempts was already bumped on the second pick, so this is the attempt just made.
    assign w_loss = (r_attempts == MAX_ATTEMPTS);
`else
    assign w_loss = 1'b0 && (r_attempts == MAX_ATTEMPTS);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FIRST;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (new_game) begin
            w_state_nxt = FIRST;
        end else begin
            case (r_state)
                FIRST:   if (w_sel_ok) w_state_nxt = SECOND;
                SECOND:  if (w_sel_ok) w_state_nxt = COMPARE;
                COMPARE: begin
                    if (w_equal)     w_state_nxt = w_last_pair ? DONE : FIRST;
                    else if (w_loss) w_state_nxt = DONE;
                    else             w_state_nxt = SHOW;
                end
                SHOW:    if (w_tmr_zero) w_state_nxt = FIRST;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = FIRST;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state == COMPARE) || (r_state == SHOW);
        game_over = (r_state == DONE);
        game_lost = (r_state == DONE) && r_lost;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_face_up  <= '0;
            r_matched  <= '0;
            r_pairs    <= '0;
            r_attempts <= '0;
            r_timer    <= '0;
            r_pick_a   <= '0;
            r_pick_b   <= '0;
            r_lost     <= 1'b0;
        end else if (new_game) begin
            r_face_up  <= '0;
            r_matched  <= '0;
            r_pairs    <= '0;
            r_attempts <= '0;
            r_timer    <= '0;
            r_pick_a   <= '0;
            r_pick_b   <= '0;
            r_lost     <= 1'b0;
        end else begin
            case (r_state)
                FIRST: if (w_sel_ok) begin
                    r_face_up <= r_face_up | w_pos_oh;
                    r_pick_a  <= pos;
                end
                SECOND: if (w_sel_ok) begin
                    r_face_up <= r_face_up | w_pos_oh;
                    r_pick_b  <= pos;
                    if (r_attempts != 8'hFF) r_attempts <= r_attempts + 8'd1;
                end
                COMPARE: begin
                    if (w_equal) begin
                        r_matched <= r_matched | w_pick_mask;
                        r_pairs   <= r_pairs + 4'd1;
                        if (w_last_pair) begin
                            r_face_up <= '1;
                            r_matched <= '1;
                        end
                    end else if (w_loss) begin
                        r_lost <= 1'b1;
                    end else begin
                        r_timer <= TMR_LOAD;
                    end
                end
                SHOW: begin
                    if (w_tmr_zero) r_face_up <= r_face_up & ~w_pick_mask;
                    else            r_timer   <= r_timer - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign face_up     = r_face_up;
    assign matched     = r_matched;
    assign pairs_found = r_pairs;
    assign attempts    = r_attempts;

endmodule
